// File: rtl/fadd_pkg.sv
// Shared constants and pipeline stage records for the fadd_pipe floating-point adder.
// Record field widths follow FADD_EW/FADD_MW, so fadd_pipe must be built with matching EW/MW.
package fadd_pkg;
  localparam int FADD_EW = 8;
  localparam int FADD_MW = 23;
  localparam int FADD_W  = 1 + FADD_EW + FADD_MW;
  localparam int FADD_FW = FADD_MW + 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [FADD_W-1:0] QNAN = {1'b0, {FADD_EW{1'b1}}, 1'b1, {(FADD_MW-1){1'b0}}};

  // S1 -> S2: ordered, aligned operands; mantissas are {hidden, frac, guard, round, sticky}
  typedef struct packed {
    logic                 sign;
    logic [FADD_EW-1:0]   expo;
    logic [FADD_FW-1:0]   mag_big;
    logic [FADD_FW-1:0]   mag_small;
    logic                 eff_sub;
    logic                 special;
    logic [FADD_W-1:0]    spec_y;
  } s1_rec_t;

  // S2 -> S3: normalised magnitude with a signed exponent wide enough to see overflow
  typedef struct packed {
    logic                     sign;
    logic signed [FADD_EW+1:0] expo;
    logic [FADD_FW-1:0]       mant;
    logic                     is_zero;
    logic                     special;
    logic [FADD_W-1:0]        spec_y;
  } s2_rec_t;
endpackage

// File: rtl/fadd_pipe_lzc.sv
// Parametrised leading-zero counter; o_cnt = N when the input is all zero.
module lzc #(
  parameter int N = 27
) (
  input  logic [N-1:0]         i_data,
  output logic [$clog2(N):0]   o_cnt,
  output logic                 o_zero
);
  localparam int CW = $clog2(N) + 1;

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_cnt = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (i_data[i]) o_cnt = CW'(N - 1 - i);
    end
  end

  assign o_zero = ~|i_data;
endmodule

// File: rtl/fadd_pipe.sv
// Three-stage pipelined IEEE-style adder/subtractor with valid/ready handshake and global stall.
// Define FADD_ROUND_EN for round-to-nearest-even in S3; otherwise S3 truncates.
module fadd_pipe
  import fadd_pkg::*;
#(
  parameter int EW = FADD_EW,
  parameter int MW = FADD_MW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [EW+MW:0]   a,
  input  logic [EW+MW:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y,
  output logic             zero,
  output logic             ovf
);
  localparam int W  = 1 + EW + MW;
  localparam int FW = MW + 4;
  localparam int AW = MW + 5;
  localparam int XW = EW + 2;
  localparam int CW = $clog2(FW) + 1;
  localparam logic [EW-1:0] EXP_ONES = '1;
  localparam logic signed [XW-1:0] EXP_MAX = $signed({2'b00, EXP_ONES});

  logic    w_stall;
  logic    r_v1, r_v2, r_v3;
  s1_rec_t r_s1, w_s1;
  s2_rec_t r_s2, w_s2;
  logic [W-1:0] r_y, w_y;
  logic    r_zero, r_ovf, w_zero, w_ovf;

  assign w_stall  = r_v3 & ~out_ready;
  assign in_ready = ~w_stall;

  // ---------------- S1: unpack / compare / swap / align ----------------
  logic          w_sa, w_sb, w_s_big, w_swap;
  logic [EW-1:0] w_ea, w_eb, w_e_big, w_e_sml, w_diff;
  logic [MW-1:0] w_fa, w_fb, w_f_big, w_f_sml;
  logic          w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [FW-1:0] w_m_big, w_m_sml, w_shifted;
  logic          w_sticky;

  assign w_sa = a[W-1];
  assign w_sb = b[W-1] ^ (op == OP_SUB);
  assign w_ea = a[W-2:MW];
  assign w_eb = b[W-2:MW];
  assign w_fa = (w_ea == '0) ? '0 : a[MW-1:0];
  assign w_fb = (w_eb == '0) ? '0 : b[MW-1:0];

  assign w_a_nan = (w_ea == EXP_ONES) && (a[MW-1:0] != '0);
  assign w_b_nan = (w_eb == EXP_ONES) && (b[MW-1:0] != '0);
  assign w_a_inf = (w_ea == EXP_ONES) && (a[MW-1:0] == '0);
  assign w_b_inf = (w_eb == EXP_ONES) && (b[MW-1:0] == '0);

  assign w_swap  = {w_eb, w_fb} > {w_ea, w_fa};
  assign w_s_big = w_swap ? w_sb : w_sa;
  assign w_e_big = w_swap ? w_eb : w_ea;
  assign w_e_sml = w_swap ? w_ea : w_eb;
  assign w_f_big = w_swap ? w_fb : w_fa;
  assign w_f_sml = w_swap ? w_fa : w_fb;
  assign w_m_big = {(w_e_big != '0), w_f_big, 3'b000};
  assign w_m_sml = {(w_e_sml != '0), w_f_sml, 3'b000};
  assign w_diff  = w_e_big - w_e_sml;

  always_comb begin
    w_shifted = '0;
    w_sticky  = 1'b0;
    if (int'(w_diff) >= MW + 3) begin
      w_sticky = |w_m_sml;
    end else begin
      w_shifted = w_m_sml >> w_diff;
      w_sticky  = |(w_m_sml & ~({FW{1'b1}} << w_diff));
    end
  end

  always_comb begin
    w_s1           = '0;
    w_s1.sign      = w_s_big;
    w_s1.expo      = w_e_big;
    w_s1.mag_big   = w_m_big;
    w_s1.mag_small = {w_shifted[FW-1:1], w_shifted[0] | w_sticky};
    w_s1.eff_sub   = w_sa ^ w_sb;
    w_s1.special   = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
      w_s1.spec_y = QNAN;
    else if (w_a_inf)
      w_s1.spec_y = {w_sa, EXP_ONES, {MW{1'b0}}};
    else
      w_s1.spec_y = {w_sb, EXP_ONES, {MW{1'b0}}};
  end

  // ---------------- S2: add-subtract / normalise ----------------
  logic [AW-1:0]        w_sum;
  logic [CW-1:0]        w_lz;
  logic                 w_lo_zero;
  logic signed [XW-1:0] w_exp_in, w_lim, w_lz_x, w_shamt;
  logic [FW-1:0]        w_norm;

  assign w_sum = r_s1.eff_sub ? ({1'b0, r_s1.mag_big} - {1'b0, r_s1.mag_small})
                              : ({1'b0, r_s1.mag_big} + {1'b0, r_s1.mag_small});

  lzc #(.N(FW)) u_lzc (
    .i_data (w_sum[FW-1:0]),
    .o_cnt  (w_lz),
    .o_zero (w_lo_zero)
  );

  // Left shift is capped so the exponent never drops below 1.
  assign w_exp_in = $signed({2'b00, r_s1.expo});
  assign w_lim    = w_exp_in - XW'(1);
  assign w_lz_x   = $signed({{(XW-CW){1'b0}}, w_lz});
  assign w_shamt  = (w_lz_x > w_lim) ? w_lim : w_lz_x;
  assign w_norm   = w_sum[FW-1:0] << w_shamt;

  always_comb begin
    w_s2         = '0;
    w_s2.sign    = r_s1.sign;
    w_s2.special = r_s1.special;
    w_s2.spec_y  = r_s1.spec_y;
    if (w_sum[AW-1]) begin
      w_s2.mant = {w_sum[AW-1:2], w_sum[1] | w_sum[0]};
      w_s2.expo = w_exp_in + XW'(1);
    end else if (w_lo_zero) begin
      w_s2.is_zero = 1'b1;
      w_s2.sign    = r_s1.sign & ~r_s1.eff_sub;
    end else if (!w_norm[FW-1]) begin
      w_s2.is_zero = 1'b1;
    end else begin
      w_s2.mant = w_norm;
      w_s2.expo = w_exp_in - w_shamt;
    end
  end

  // ---------------- S3: round / pack ----------------
  logic                 w_rnd_up;
  logic [MW+1:0]        w_mr;
  logic signed [XW-1:0] w_exp3;
  logic [MW-1:0]        w_frac3;
  logic                 w_unused;

`ifdef FADD_ROUND_EN
  assign w_rnd_up = r_s2.mant[2] & (r_s2.mant[1] | r_s2.mant[0] | r_s2.mant[3]);
`else
  assign w_rnd_up = 1'b0;
`endif

  assign w_mr     = {1'b0, r_s2.mant[FW-1:3]} + {{(MW+1){1'b0}}, w_rnd_up};
  assign w_exp3   = r_s2.expo + (w_mr[MW+1] ? XW'(1) : XW'(0));
  assign w_frac3  = w_mr[MW+1] ? '0 : w_mr[MW-1:0];
  assign w_unused = ^{r_s2.mant[2:0], w_mr[MW]};

  always_comb begin
    w_y   = {r_s2.sign, w_exp3[EW-1:0], w_frac3};
    w_ovf = 1'b0;
    if (r_s2.special) begin
      w_y = r_s2.spec_y;
    end else if (r_s2.is_zero) begin
      w_y = {r_s2.sign, {(W-1){1'b0}}};
    end else if (w_exp3 >= EXP_MAX) begin
      w_y   = {r_s2.sign, EXP_ONES, {MW{1'b0}}};
      w_ovf = 1'b1;
    end
  end

  assign w_zero = (w_y[W-2:0] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_y    <= '0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (!w_stall) begin
      r_v1   <= in_valid;
      r_s1   <= w_s1;
      r_v2   <= r_v1;
      r_s2   <= w_s2;
      r_v3   <= r_v2;
      r_y    <= w_y;
      r_zero <= w_zero;
      r_ovf  <= w_ovf;
    end
  end

  assign out_valid = r_v3;
  assign y         = r_y;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
endmodule

// File: doc/fadd_pipe.md
FADD_PIPE -- requirements
Module: fadd_pipe

Interface
REQ-001 Parameter EW, default 8, exponent width in bits.
REQ-002 Parameter MW, default 23, stored mantissa width in bits; word width W = 1+EW+MW.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 op  input  1  0 = a+b, 1 = a-b; sampled with the operands.
REQ-008 a, b  input  W  IEEE-style operands {sign, exponent, mantissa}.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 y  output  W  result word.
REQ-012 zero, ovf  output  1 each  result is zero; exponent overflow saturated to infinity.

Function
REQ-013 Transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
REQ-014 Three register stages: S1 unpack/compare/swap/align; S2 add-subtract/normalise; S3 round/pack; latency exactly 3 cycles with no stall.
REQ-015 Global stall = out_valid && !out_ready; in_ready = !stall; while stalled, all stage registers hold.
REQ-016 Sustained throughput of one result per cycle when out_ready stays high; no loss or duplication under any in_valid/out_ready pattern.
REQ-017 S1 inverts b's sign when op=1, orders operands by magnitude {exp, mant} so the larger is first, and right-shifts the smaller hidden-bit mantissa by the exponent difference, keeping guard, round and sticky bits.
REQ-018 Shift amounts >= MW+3 clear the shifted mantissa and set sticky if it was non-zero.
REQ-019 Result sign = sign of the larger-magnitude operand; exact cancellation gives +0.
REQ-020 S2 handles carry-out by right-shifting 1 and incrementing the exponent; otherwise it left-normalises by the leading-zero count, limited so the exponent does not go below 1.
REQ-021 Denormal inputs (exponent 0) are treated as signed zero; a result with exponent below 1 is flushed to signed zero.
REQ-022 A biased exponent >= 2^EW-1 after normalise or round gives infinity {s, all-ones, 0} and ovf=1.
REQ-023 Special cases: NaN operand or inf-inf gives quiet NaN {0, all-ones, 1 followed by zeros}; a single infinity operand gives that infinity, sign adjusted for op.
REQ-024 zero=1 exactly when exponent and mantissa of y are both 0.
REQ-025 Arithmetic width: the S2 adder is MW+5 bits (carry, hidden bit, MW bits, guard, round/sticky); the exponent path is EW+2 bits signed to detect underflow and overflow.

Reset
REQ-026 rst clears all stage valid bits immediately; out_valid=0, y=0, zero=0 and ovf=0 while rst is high.
REQ-027 Operations in flight at reset are discarded and never emerge; in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-028 With FADD_ROUND_EN defined, S3 rounds to nearest, ties to even, using guard, round and sticky; rounding carry renormalises and may raise ovf.
REQ-029 Without FADD_ROUND_EN, S3 truncates (round toward zero); latency and interface are unchanged.

Structure
REQ-030 Package fadd_pkg holds default EW/MW constants, the op encodings (OP_ADD, OP_SUB), the quiet-NaN constant, and the S1/S2 stage-record typedefs.
REQ-031 One sub-module, lzc: parametrised leading-zero counter with input width N, count output of width $clog2(N)+1, and an all-zero flag; used in S2.

Verification
REQ-032 Add: a=0x3F800000, b=0x3F800000, op=0 -> y=0x40000000 exactly 3 cycles later; zero=0, ovf=0.
REQ-033 Cancellation: a=0x3F800000, b=0x3F800000, op=1 -> y=0x00000000, zero=1.
REQ-034 Rounding: 0x3F800000+0x33800000 -> 0x3F800000, and 0x3F800001+0x33800000 -> 0x3F800002 with FADD_ROUND_EN; the second case gives 0x3F800001 without FADD_ROUND_EN.
REQ-035 Overflow: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, ovf=1; 0x7F800000-0x7F800000 -> 0x7FC00000.
REQ-036 Backpressure: issue 6 back-to-back ops, hold out_ready=0 for 5 cycles -> in_ready drops, all 6 results arrive in order with no duplicates.
REQ-037 Reset mid-flight: assert rst with 2 ops in flight -> out_valid=0 immediately; no result appears after release until new input is issued.
